hex_scroll_ctrl: RTL and testbench
==================================

HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 address  input  2  Avalon-MM word address (0 CTRL, 1 DATA, 2 DIV, 3 STATUS).
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-007 writedata  input  32  write data.
REQ-008 readdata  output  32  read data, combinational from address, zero wait states.
REQ-009 hex3, hex2, hex1, hex0  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex3 is leftmost.

Function
REQ-010 CTRL SHALL be a read/write register: bit0 RUN, bit1 DIR (0 = pos increments, 1 = pos decrements), bit2 ONESHOT, bit3 BLINK; all other bits read 0.
REQ-011 DATA SHALL hold an 8-nibble message; nibble n is writedata[4n+3:4n], and nibble 7 is the first character.
REQ-012 DIV SHALL be a 24-bit read/write step period; bits 31:24 read 0; one step occurs every DIV+1 cycles, so DIV=0 steps every cycle.
REQ-013 STATUS SHALL be read-only: bits 2:0 pos, bit3 DONE, bits 5:4 state encoding (0 IDLE, 1 RUN, 2 DONE); writes to it are ignored.
REQ-014 Window digit k (0..3, with k=0 on hex3) SHALL display nibble 7-((pos+k) mod 8), so pos=0 shows bits 31:16.
REQ-015 Segment encoding SHALL be standard active-low hex: 0 -> 0x40, 1 -> 0x79, 8 -> 0x00, A -> 0x08, F -> 0x0E, and so on for all 16 values.
REQ-016 FSM states IDLE, RUN, DONE: IDLE -> RUN when CTRL is written with RUN=1; RUN -> IDLE when CTRL is written with RUN=0; RUN -> DONE when ONESHOT=1 and pos returns to 0 after 8 steps; DONE -> RUN or IDLE only on a CTRL write.
REQ-017 In RUN, a 24-bit counter SHALL increment every cycle; when it equals DIV it SHALL clear and pos SHALL step by ±1 modulo 8 (wrap 7->0 or 0->7).
REQ-018 In IDLE and DONE, the counter and pos SHALL hold, and the display SHALL show the current window.
REQ-019 A DATA write SHALL set pos=0 and counter=0 on the same edge, overriding any coincident step.
REQ-020 A DIV write SHALL clear the counter, and no step SHALL occur on that edge.
REQ-021 A CTRL write with RUN=1 from DONE SHALL clear DONE, set pos=0, and enter RUN; a CTRL write in any state SHALL clear DONE.
REQ-022 A CTRL write that changes DIR SHALL take effect from the next step, and pos SHALL be unchanged by the write.
REQ-023 The one-shot step count SHALL be 8 steps in either direction.
REQ-024 Register updates SHALL take effect on the clock edge of the write; the display SHALL change one cycle after a pos or DATA change (registered outputs).

Reset
REQ-025 On reset_n low, the block SHALL asynchronously set CTRL=0, DATA=0, DIV=0, counter=0, pos=0, DONE=0, state=IDLE, and blink phase=0.
REQ-026 After reset, hex3..hex0 SHALL each be 0x40 (digit 0).
REQ-027 A reset asserted mid-RUN SHALL abort immediately, with no partial step retained.

Configuration
REQ-028 The macro HEX_SCROLL_BLINK_EN SHALL control the blink feature.
REQ-029 With HEX_SCROLL_BLINK_EN defined and BLINK=1, a blink phase bit SHALL toggle on every step, and while phase=1 all four displays SHALL be 0x7F (blank).
REQ-030 With BLINK=0, the blink phase SHALL be forced to 0.
REQ-031 Without HEX_SCROLL_BLINK_EN, CTRL bit3 SHALL read 0 and be ignored, no phase logic SHALL exist, and the displays SHALL never blank.

Verification
REQ-032 Reset then read all registers -> 0; hex3..hex0 = 0x40.
REQ-033 DATA=0x0123_4567, DIV=3, CTRL=0x1 -> pos steps every 4 cycles; after 1 step hex3..0 show 1,2,3,4; after 8 steps pos=0 and the window is back to 0,1,2,3.
REQ-034 Same setup with CTRL=0x3 (DIR=1) -> first step pos=7, window 7,0,1,2.
REQ-035 CTRL=0x5, DIV=0 -> DONE after exactly 8 cycles; STATUS=0x28 (state 2, DONE=1, pos=0); pos holds; a CTRL write of 0x1 clears DONE and enters RUN.
REQ-036 A DATA write on the same edge as a step -> pos=0 and counter=0; the write wins.
REQ-037 With HEX_SCROLL_BLINK_EN and CTRL=0x9, DIV=1 -> displays alternate between the window and 0x7F every 2 cycles; without the macro, CTRL reads 0x1.

Source files
------------

// File: rtl/hex_scroll_ctrl_if.sv
// Avalon-MM slave bus for hex_scroll_ctrl: word address, chip select,
// active-low write strobe and 32-bit data in both directions.
interface hex_scroll_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolls an 8-nibble message through a 4-digit seven-segment window.
// Optional blink feature enabled by defining HEX_SCROLL_BLINK_EN.
module hex_scroll_ctrl (
    input  logic                    clk,
    input  logic                    reset_n,
    hex_scroll_ctrl_if.slave        bus,
    output logic [6:0]              hex3,
    output logic [6:0]              hex2,
    output logic [6:0]              hex1,
    output logic [6:0]              hex0
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_DATA   = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

`ifdef HEX_SCROLL_BLINK_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic [3:0]  r_ctrl;
    logic [31:0] r_data;
    logic [23:0] r_div;
    logic [23:0] r_cnt;
    logic [2:0]  r_pos;
    logic [3:0]  r_steps;
    logic        r_done;
    logic [1:0]  r_state;
    logic [6:0]  r_hex [4];

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_data;
    logic        w_wr_div;
    logic        w_tick;
    logic        w_step;
    logic        w_shot_done;
    logic [2:0]  w_pos_next;
    logic        w_blank;

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_wr_ctrl  = w_wr && (bus.address == A_CTRL);
    assign w_wr_data  = w_wr && (bus.address == A_DATA);
    assign w_wr_div   = w_wr && (bus.address == A_DIV);

    // DATA and DIV writes both restart the period, so they suppress a coincident step.
    assign w_tick      = (r_state == S_RUN) && (r_cnt == r_div);
    assign w_step      = w_tick && !w_wr_data && !w_wr_div;
    assign w_pos_next  = r_ctrl[1] ? (r_pos - 3'd1) : (r_pos + 3'd1);
    assign w_shot_done = w_step && r_ctrl[2] && (w_pos_next == 3'd0) && (r_steps >= 4'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= 4'h0;
            r_data <= 32'h0;
            r_div  <= 24'h0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= bus.writedata[3:0] & CTRL_MASK;
            if (w_wr_data) r_data <= bus.writedata;
            if (w_wr_div)  r_div  <= bus.writedata[23:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 24'h0;
        end else if (w_wr_data || w_wr_div) begin
            r_cnt <= 24'h0;
        end else if (r_state == S_RUN) begin
            r_cnt <= w_tick ? 24'h0 : r_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos <= 3'd0;
        end else if (w_wr_data) begin
            r_pos <= 3'd0;
        end else if (w_wr_ctrl && (r_state == S_DONE) && bus.writedata[0]) begin
            r_pos <= 3'd0;
        end else if (w_step) begin
            r_pos <= w_pos_next;
        end
    end

    // Saturating step count so a one-shot needs at least a full lap before DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_steps <= 4'd0;
        end else if (w_wr_data || w_wr_ctrl) begin
            r_steps <= 4'd0;
        end else if (w_step && (r_steps != 4'd8)) begin
            r_steps <= r_steps + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_state <= bus.writedata[0] ? S_RUN : S_IDLE;
            r_done  <= 1'b0;
        end else if (w_shot_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic r_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= 1'b0;
        end else if (!r_ctrl[3]) begin
            r_phase <= 1'b0;
        end else if (w_step) begin
            r_phase <= ~r_phase;
        end
    end

    assign w_blank = r_phase;
`else
    assign w_blank = 1'b0;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Digit gi sits gi places right of hex3; 3-bit arithmetic gives the mod-8 wrap.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [2:0] w_idx;
            logic [3:0] w_nib;

            assign w_idx = 3'd7 - (r_pos + 3'(gi));
            assign w_nib = r_data[{w_idx, 2'b00} +: 4];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_hex[gi] <= 7'h40;
                end else begin
                    r_hex[gi] <= w_blank ? 7'h7F : seg7(w_nib);
                end
            end
        end
    endgenerate

    assign hex3 = r_hex[0];
    assign hex2 = r_hex[1];
    assign hex1 = r_hex[2];
    assign hex0 = r_hex[3];

    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            A_CTRL:   bus.readdata = {28'h0, r_ctrl};
            A_DATA:   bus.readdata = r_data;
            A_DIV:    bus.readdata = {8'h0, r_div};
            A_STATUS: bus.readdata = {26'h0, r_state, r_done, r_pos};
            default:  bus.readdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Scoreboard bench for hex_scroll_ctrl: expectations are queued as stimulus
// is applied and popped when registers or displays are sampled.
module tb_hex_scroll_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [6:0] hex3, hex2, hex1, hex0;

    hex_scroll_ctrl_if bus();

    hex_scroll_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .hex3    (hex3),
        .hex2    (hex2),
        .hex1    (hex1),
        .hex0    (hex0)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [31:0] BLANK = 32'h0FFF_FFFF;

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] win(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d);
        return {4'h0, seg_ref(a), seg_ref(b), seg_ref(c), seg_ref(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("chk %-14s got 0x%08h ok", tag, got);
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_cmp(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            chk(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic rd_cmp(input logic [1:0] a);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        pop_cmp(bus.readdata);
        bus.chipselect = 1'b0;
    endtask

    task automatic hex_cmp();
        pop_cmp({4'h0, hex3, hex2, hex1, hex0});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        $display("wr  addr=%0d data=0x%08h", a, d);
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        wait_edges(1);

        // Reset state
        push_exp("rst_ctrl", 32'h0);   rd_cmp(2'd0);
        push_exp("rst_data", 32'h0);   rd_cmp(2'd1);
        push_exp("rst_hex", win(4'h0, 4'h0, 4'h0, 4'h0)); hex_cmp();
        wait_edges(1);
        push_exp("rst_div", 32'h0);    rd_cmp(2'd2);
        push_exp("rst_status", 32'h0); rd_cmp(2'd3);

        // Forward scroll, DIV=3
        wr(2'd1, 32'h0123_4567); wr(2'd2, 32'd3); wr(2'd0, 32'h1);
        push_exp("fwd_ctrl", 32'h1); rd_cmp(2'd0);
        push_exp("fwd_div", 32'h3);  rd_cmp(2'd2);
        wait_edges(4);
        push_exp("fwd_step1", 32'h11); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("fwd_hex1", win(4'h1, 4'h2, 4'h3, 4'h4)); hex_cmp();
        wait_edges(27);
        push_exp("fwd_step8", 32'h10); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("fwd_hex0", win(4'h0, 4'h1, 4'h2, 4'h3)); hex_cmp();

        // Reverse scroll, then DIR change mid-run
        wr(2'd0, 32'h0); wr(2'd1, 32'h0123_4567); wr(2'd2, 32'd3); wr(2'd0, 32'h3);
        wait_edges(4);
        push_exp("rev_step1", 32'h17); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("rev_hex7", win(4'h7, 4'h0, 4'h1, 4'h2)); hex_cmp();
        wr(2'd0, 32'h1);
        push_exp("dir_hold", 32'h17); rd_cmp(2'd3);
        wait_edges(2);
        push_exp("dir_next", 32'h10); rd_cmp(2'd3);

        // STATUS is read-only
        wr(2'd3, 32'hFFFF_FFFF);
        push_exp("stat_ro", 32'h10); rd_cmp(2'd3);
        push_exp("stat_ro_ctrl", 32'h1); rd_cmp(2'd0);

        // One-shot with DIV=0
        wr(2'd0, 32'h0); wr(2'd1, 32'hFEDC_BA98); wr(2'd2, 32'd0); wr(2'd0, 32'h5);
        wait_edges(7);
        push_exp("shot_7", 32'h17); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("shot_done", 32'h28); rd_cmp(2'd3);
        wait_edges(2);
        push_exp("shot_hold", 32'h28); rd_cmp(2'd3);
        push_exp("shot_hex", win(4'hF, 4'hE, 4'hD, 4'hC)); hex_cmp();
        wr(2'd0, 32'h1);
        push_exp("shot_rerun", 32'h10); rd_cmp(2'd3);

        // DATA write on a step edge, then DIV write on a step edge
        wr(2'd0, 32'h0); wr(2'd2, 32'd3); wr(2'd1, 32'h0123_4567); wr(2'd0, 32'h1);
        wait_edges(3);
        wr(2'd1, 32'h89AB_CDEF);
        push_exp("dcol_pos", 32'h10); rd_cmp(2'd3);
        wait_edges(3);
        push_exp("dcol_cnt", 32'h10); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("dcol_step", 32'h11); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("dcol_hex", win(4'h9, 4'hA, 4'hB, 4'hC)); hex_cmp();
        wait_edges(2);
        wr(2'd2, 32'd3);
        push_exp("div_nostep", 32'h11); rd_cmp(2'd3);
        wait_edges(3);
        push_exp("div_cnt", 32'h11); rd_cmp(2'd3);
        wait_edges(1);
        push_exp("div_step", 32'h12); rd_cmp(2'd3);

        // Asynchronous reset mid-run
        wait_edges(2);
        #2 reset_n = 1'b0;
        #1;
        push_exp("arst_status", 32'h0); rd_cmp(2'd3);
        push_exp("arst_ctrl", 32'h0);   rd_cmp(2'd0);
        push_exp("arst_hex", win(4'h0, 4'h0, 4'h0, 4'h0)); hex_cmp();
        @(negedge clk) reset_n = 1'b1;
        wait_edges(3);
        push_exp("arst_idle", 32'h0); rd_cmp(2'd3);

        // Blink
        wr(2'd1, 32'h0123_4567); wr(2'd2, 32'd1); wr(2'd0, 32'h9);
`ifdef HEX_SCROLL_BLINK_EN
        push_exp("blk_ctrl", 32'h9); rd_cmp(2'd0);
        wait_edges(2);
        push_exp("blk_win0", win(4'h0, 4'h1, 4'h2, 4'h3)); hex_cmp();
        wait_edges(1);
        push_exp("blk_blank1", BLANK); hex_cmp();
        wait_edges(2);
        push_exp("blk_win2", win(4'h2, 4'h3, 4'h4, 4'h5)); hex_cmp();
        wait_edges(2);
        push_exp("blk_blank2", BLANK); hex_cmp();
`else
        push_exp("blk_ctrl", 32'h1); rd_cmp(2'd0);
        wait_edges(3);
        push_exp("blk_win1", win(4'h1, 4'h2, 4'h3, 4'h4)); hex_cmp();
        wait_edges(2);
        push_exp("blk_win2", win(4'h2, 4'h3, 4'h4, 4'h5)); hex_cmp();
`endif

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
